// File: rtl/grayscale_pkg.sv
// grayscale_pkg
//   Shared types and helpers for the grayscale datapath.
//   - t_gs_mode   : conversion mode carried with every beat
//   - LUMA_*      : BT.601 integer luma weights (sum to 256)
//   - *_LSB       : bit offsets of the B/G/R/A fields inside a pixel
//   - gs_convert  : converts one 32-bit BGRA pixel according to a mode
package grayscale_pkg;

  typedef enum logic [1:0] {
    GS_LUMA601 = 2'd0,
    GS_FAST    = 2'd1,
    GS_PASS    = 2'd2,
    GS_PASS2   = 2'd3
  } t_gs_mode;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  localparam int B_LSB = 0;
  localparam int G_LSB = 8;
  localparam int R_LSB = 16;
  localparam int A_LSB = 24;

  // Width of the converted part of a pixel; wider pixels pass their upper bits through.
  localparam int GS_PX_W = 32;

  // Luma weights sum to 256, so the 601 sum peaks at 255*256+128 and
  // the shifted result never exceeds 255: no saturation stage needed.
  function automatic logic [31:0] gs_convert(input logic [31:0] px, input t_gs_mode mode);
    logic [7:0]  r, g, b, a, y;
    logic [16:0] luma;
    logic [9:0]  fast;
    logic [31:0] res;
    b    = px[B_LSB +: 8];
    g    = px[G_LSB +: 8];
    r    = px[R_LSB +: 8];
    a    = px[A_LSB +: 8];
    luma = 17'(LUMA_R) * {9'd0, r} + 17'(LUMA_G) * {9'd0, g}
         + 17'(LUMA_B) * {9'd0, b} + 17'd128;
    fast = {2'd0, r} + {1'b0, g, 1'b0} + {2'd0, b} + 10'd2;
    y    = 8'd0;
    res  = px;
    case (mode)
      GS_LUMA601: begin
        y   = 8'(luma >> 8);
        res = {a, y, y, y};
      end
      GS_FAST: begin
        y   = 8'(fast >> 2);
        res = {a, y, y, y};
      end
      default: res = px;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/grayscale_fifo.sv
// grayscale_fifo
//   Synchronous first-word-fall-through FIFO with occupancy outputs.
//   Ports:
//     clk, reset_n      clock, async active-low reset (pointers/count only)
//     wr_en, wr_data    push request; accepted unless full (push+pop when full is fine)
//     rd_en             pop request; ignored when empty
//     rd_data           head entry, forced to 0 while empty
//     empty             no entries
//     count             current occupancy
//     count_nxt         occupancy after this cycle's push/pop
//     overflow          push request dropped because the FIFO was full (pulse)
module grayscale_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = rd_en & ~empty;
  // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
  assign do_push  = wr_en & (~full | do_pop);
  assign overflow = wr_en & ~do_push;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + CW'(1);
    if (do_pop && !do_push) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/grayscale_flow_pipe.sv
// grayscale_flow_pipe
//   Converts DATA_WIDTH/PIXEL_WIDTH packed BGRA pixels per beat to gray through a
//   fixed-latency pipeline feeding an output FIFO.
//   Ports:
//     clk, reset_n            clock, async active-low reset
//     cfg_mode                0=BT.601 luma, 1=(R+2G+B)/4, 2/3=passthrough; sampled per beat
//     in_valid/in_data/in_ready    input beat stream
//     out_valid/out_data/out_ready output beat stream (FIFO head, fall-through)
//     stat_clear              synchronous clear of the statistics
//     stat_beats              beats popped since reset/clear
//     stat_hwm                peak FIFO occupancy since reset/clear
//     stat_ovf                sticky: a push hit a full FIFO
//
//   Handshake: a beat moves on a port in every cycle where valid and ready are both high
//   at the rising clock edge. valid is held with stable data until taken, and neither
//   side lets its valid depend combinationally on the other side's ready.
module grayscale_flow_pipe
  import grayscale_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int PIXEL_WIDTH = 32,
  parameter int PIPE_STAGES = 3,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    cfg_mode,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  input  logic                          stat_clear,
  output logic [31:0]                   stat_beats,
  output logic [$clog2(FIFO_DEPTH):0]   stat_hwm,
  output logic                          stat_ovf
);

  localparam int LANES = DATA_WIDTH / PIXEL_WIDTH;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int SW    = CW + 1;

  logic                  ready_en;
  logic                  accept;
  logic                  pop;
  logic [PIPE_STAGES-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_data [PIPE_STAGES];
  t_gs_mode              pipe_mode [PIPE_STAGES];
  logic [DATA_WIDTH-1:0] conv_data;
  logic [SW-1:0]         inflight;
  logic [SW-1:0]         credit_sum;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         fifo_count_nxt;
  logic                  fifo_ovf;

  assign accept    = in_valid & in_ready;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Every beat in the pipe or the FIFO holds one credit. Admitting only while the total
  // is below FIFO_DEPTH means the pipe can advance unconditionally and never overflow.
  // ready_en keeps in_ready low until the first edge after reset release.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_STAGES; i++) begin
      inflight = inflight + SW'(pipe_vld[i]);
    end
    credit_sum = SW'(fifo_count) + inflight;
    in_ready   = ready_en && (credit_sum < SW'(FIFO_DEPTH));
  end

  // Raw data and its mode travel together; conversion happens at the pipe tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      pipe_vld <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        pipe_data[s] <= '0;
        pipe_mode[s] <= GS_LUMA601;
      end
    end else begin
      ready_en    <= 1'b1;
      pipe_vld[0] <= accept;
      if (accept) begin
        pipe_data[0] <= in_data;
        pipe_mode[0] <= t_gs_mode'(cfg_mode);
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_data[s] <= pipe_data[s-1];
        pipe_mode[s] <= pipe_mode[s-1];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign conv_data[l*PIXEL_WIDTH +: GS_PX_W] =
      gs_convert(pipe_data[PIPE_STAGES-1][l*PIXEL_WIDTH +: GS_PX_W], pipe_mode[PIPE_STAGES-1]);
    if (PIXEL_WIDTH > GS_PX_W) begin : g_pad
      assign conv_data[l*PIXEL_WIDTH+GS_PX_W +: PIXEL_WIDTH-GS_PX_W] =
        pipe_data[PIPE_STAGES-1][l*PIXEL_WIDTH+GS_PX_W +: PIXEL_WIDTH-GS_PX_W];
    end
  end

  if (LANES * PIXEL_WIDTH < DATA_WIDTH) begin : g_tail
    assign conv_data[DATA_WIDTH-1:LANES*PIXEL_WIDTH] =
      pipe_data[PIPE_STAGES-1][DATA_WIDTH-1:LANES*PIXEL_WIDTH];
  end

  grayscale_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (pipe_vld[PIPE_STAGES-1]),
    .wr_data   (conv_data),
    .rd_en     (out_ready),
    .rd_data   (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt),
    .overflow  (fifo_ovf)
  );

  // stat_clear wins over any same-cycle update, including the high-water mark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_beats <= '0;
      stat_hwm   <= '0;
      stat_ovf   <= 1'b0;
    end else if (stat_clear) begin
      stat_beats <= '0;
      stat_hwm   <= '0;
      stat_ovf   <= 1'b0;
    end else begin
      if (pop) stat_beats <= stat_beats + 32'd1;
      if (fifo_count_nxt > stat_hwm) stat_hwm <= fifo_count_nxt;
      if (fifo_ovf) stat_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grayscale_flow_pipe.sv
// tb_grayscale_flow_pipe
//   Drives grayscale_flow_pipe with directed and random traffic and compares every
//   cycle against a queue-based model of the block's externally visible behaviour.
module tb_grayscale_flow_pipe;

  localparam int DW    = 512;
  localparam int PW    = 32;
  localparam int PS    = 3;
  localparam int FD    = 64;
  localparam int LANES = DW / PW;
  localparam int CW    = $clog2(FD) + 1;

  logic          clk;
  logic          reset_n;
  logic [1:0]    cfg_mode;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          stat_clear;
  logic [31:0]   stat_beats;
  logic [CW-1:0] stat_hwm;
  logic          stat_ovf;

  grayscale_flow_pipe #(
    .DATA_WIDTH  (DW),
    .PIXEL_WIDTH (PW),
    .PIPE_STAGES (PS),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_mode   (cfg_mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .stat_clear (stat_clear),
    .stat_beats (stat_beats),
    .stat_hwm   (stat_hwm),
    .stat_ovf   (stat_ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_px(input logic [31:0] px, input logic [1:0] mode);
    int r, g, b, a, y;
    b = int'(px[7:0]);
    g = int'(px[15:8]);
    r = int'(px[23:16]);
    a = int'(px[31:24]);
    if (mode == 2'd0)      y = (77 * r + 150 * g + 29 * b + 128) / 256;
    else if (mode == 2'd1) y = (r + 2 * g + b + 2) / 4;
    else                   return px;
    return {8'(a), 8'(y), 8'(y), 8'(y)};
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input logic [1:0] mode);
    logic [DW-1:0] o;
    for (int l = 0; l < LANES; l++) o[l*PW +: PW] = model_px(d[l*PW +: PW], mode);
    return o;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*PW +: PW] = $urandom;
    return d;
  endfunction

  // Scoreboard: every accepted, not yet popped beat with the cycle it was accepted in.
  logic [DW-1:0] exp_q[$];
  int            exp_t[$];
  int            cyc = 0;
  int            since_rel = 0;
  int            m_beats = 0;
  int            m_hwm = 0;
  bit            prev_clear = 0;

  // Compare process: sample mid-cycle, check, then advance the model by this cycle's events.
  always @(negedge clk) begin
    int  occ;
    bit  exp_rdy;
    if (!reset_n) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check_data("rst_out_data", out_data, '0);
      check("rst_stat_beats", stat_beats, 0);
      check("rst_stat_hwm", stat_hwm, 0);
      check("rst_stat_ovf", stat_ovf, 0);
      exp_q.delete();
      exp_t.delete();
      m_beats    = 0;
      m_hwm      = 0;
      prev_clear = 0;
      since_rel  = 0;
    end else begin
      // A beat is visible PS+1 cycles after its accept cycle.
      occ = 0;
      foreach (exp_t[i]) if (exp_t[i] + PS + 1 <= cyc) occ++;
      exp_rdy = (since_rel > 0) && (exp_q.size() < FD);
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, occ > 0);
      if (occ > 0) check_data("out_data", out_data, exp_q[0]);
      if (prev_clear) m_hwm = 0;
      else if (occ > m_hwm) m_hwm = occ;
      check("stat_hwm", stat_hwm, m_hwm);
      check("stat_beats", stat_beats, m_beats);
      check("stat_ovf", stat_ovf, 0);
      if (occ > 0 && out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_t.pop_front());
        if (!stat_clear) m_beats++;
      end
      if (stat_clear) m_beats = 0;
      prev_clear = stat_clear;
      if (in_valid && exp_rdy) begin
        exp_q.push_back(model_beat(in_data, cfg_mode));
        exp_t.push_back(cyc);
      end
      since_rel++;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One beat of identical pixels; checks acceptance, latency and the converted value.
  task automatic send_one(input logic [31:0] px, input logic [1:0] mode, input logic [31:0] exp_px,
                          input string name);
    int k;
    next_cycle();
    in_valid  = 1'b1;
    in_data   = {LANES{px}};
    cfg_mode  = mode;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_accept"}, in_ready, 1);
    next_cycle();
    in_valid = 1'b0;
    cfg_mode = $urandom_range(0, 3);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    check({name, "_latency"}, k, PS + 1);
    check_data({name, "_data"}, out_data, {LANES{exp_px}});
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int acc;
  int guard;

  initial begin
    reset_n    = 1'b1;
    cfg_mode   = 2'd0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    stat_clear = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Hand-computed values that pin the model.
    // (77*255+128)>>8 = 19763>>8 = 77 = 0x4D
    check("pin_601", model_px(32'h80FF0000, 2'd0), 32'h804D4D4D);
    // (16+510+32+2)>>2 = 140 = 0x8C
    check("pin_fast", model_px(32'h0010FF20, 2'd1), 32'h008C8C8C);
    check("pin_pass", model_px(32'h12345678, 2'd2), 32'h12345678);
    check("pin_601_white", model_px(32'h11FFFFFF, 2'd0), 32'h11FFFFFF);

    send_one(32'h80FF0000, 2'd0, 32'h804D4D4D, "luma_red");
    send_one(32'h0010FF20, 2'd1, 32'h008C8C8C, "fast");
    send_one(32'hDEADBEEF, 2'd2, 32'hDEADBEEF, "pass2");
    send_one(32'hCAFEF00D, 2'd3, 32'hCAFEF00D, "pass3");
    send_one(32'h11FFFFFF, 2'd0, 32'h11FFFFFF, "luma_white");

    // Fill with no consumer: exactly FD beats admitted.
    next_cycle();
    acc = 0;
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'b1;
      in_data  = rand_beat();
      cfg_mode = $urandom_range(0, 3);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("fill_accepted", acc, FD);
    check("fill_in_ready", in_ready, 0);
    check("fill_hwm", stat_hwm, FD);
    check("fill_ovf", stat_ovf, 0);
    check("fill_out_valid", out_valid, 1);

    // Push and pop together while full, with a stats clear in the middle.
    next_cycle();
    for (int i = 0; i < 100; i++) begin
      in_valid   = 1'b1;
      in_data    = rand_beat();
      cfg_mode   = $urandom_range(0, 3);
      out_ready  = 1'b1;
      stat_clear = (i == 50);
      next_cycle();
    end
    stat_clear = 1'b0;
    in_valid   = 1'b0;
    repeat (80) next_cycle();
    @(negedge clk);
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);

    // Push into an empty FIFO while the consumer is always ready.
    next_cycle();
    for (int i = 0; i < 30; i++) begin
      in_valid = i[0];
      in_data  = rand_beat();
      cfg_mode = $urandom_range(0, 3);
      next_cycle();
    end
    in_valid = 1'b0;
    repeat (10) next_cycle();

    // Reset with beats both in the pipe and in the FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 23; i++) begin
      in_valid = 1'b1;
      in_data  = rand_beat();
      cfg_mode = $urandom_range(0, 3);
      next_cycle();
    end
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_beats", stat_beats, 0);
    check("midrst_hwm", stat_hwm, 0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Random traffic: 10000 beats with per-beat mode changes.
    next_cycle();
    stat_clear = 1'b1;
    next_cycle();
    stat_clear = 1'b0;
    acc   = 0;
    guard = 0;
    while (acc < 10000 && guard < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_beat();
      cfg_mode  = $urandom_range(0, 3);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      guard++;
      next_cycle();
    end
    check("rand_accepted", acc, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      next_cycle();
      guard++;
    end
    check("rand_drained", exp_q.size(), 0);
    @(negedge clk);
    check("rand_stat_beats", stat_beats, 10000);
    check("rand_out_valid", out_valid, 0);
    check("rand_ovf", stat_ovf, 0);

    next_cycle();
    out_ready = 1'b0;
    repeat (3) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
